keypad_hex_entry: RTL
=====================

KEYPAD_HEX_ENTRY -- requirements
Module: keypad_hex_entry

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning bit width of the assembled entry value (multiple of 4, >= 8).
REQ-002 SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles each column is driven (>= 4).
REQ-003 SHALL have parameter DEBOUNCE_CNT, default 1000000, meaning consecutive stable cycles needed to accept a press or release (>= 2).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port row_in  input  4  keypad rows, active-low, asynchronous pins.
REQ-007 SHALL have port clr  input  1  synchronous clear of the entry value and digit count.
REQ-008 SHALL have port col_out  output  4  keypad column drive, active-low, one-cold.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse per accepted key.
REQ-010 SHALL have port key_code  output  4  hex code of the last accepted key.
REQ-011 SHALL have port entry_value  output  WIDTH  assembled hex entry, newest digit in bits [3:0].
REQ-012 SHALL have port digit_count  output  $clog2(WIDTH/4)+1  digits entered, saturating at WIDTH/4.
REQ-013 SHALL have port key_held  output  1  high in HOLD and RELEASE states.

Function
REQ-014 SHALL pass row_in through a two-flop synchronizer; all row decisions use the synchronized value rows_s.
REQ-015 SHALL use column index c (0..3) with col_out = ~(4'b0001 << c); col_out advances 1110->1101->1011->0111->1110.
REQ-016 SHALL implement states SCAN, DEBOUNCE, HOLD, RELEASE, with counters scan_cnt (0..SCAN_DIV-1) and db_cnt (0..DEBOUNCE_CNT-1).
REQ-017 SCAN: scan_cnt increments each cycle. At scan_cnt==SCAN_DIV-1: if any rows_s bit is 0, go to DEBOUNCE, latch c, latch lowest-index low row r, and set db_cnt=0. Otherwise advance c and set scan_cnt=0.
REQ-018 DEBOUNCE: col_out stays frozen. If rows_s[r]==1, return to SCAN with c advanced and scan_cnt=0. Otherwise db_cnt increments. At db_cnt==DEBOUNCE_CNT-1, go to HOLD and accept the key.
REQ-019 Key acceptance SHALL occur on the single edge entering HOLD: key_valid=1 for exactly that cycle; key_code=map(r,c); entry_value <= {entry_value[WIDTH-5:0], key_code}; digit_count increments, saturating.
REQ-020 map(r,c) SHALL be: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = 0,F,E,D (columns 0..3).
REQ-021 HOLD: col_out stays frozen. When rows_s==4'b1111, go to RELEASE with db_cnt=0.
REQ-022 RELEASE: if any rows_s bit is 0, return to HOLD with no new key. Otherwise db_cnt increments. At db_cnt==DEBOUNCE_CNT-1, go to SCAN with c advanced and scan_cnt=0.
REQ-023 A held key SHALL produce exactly one key_valid; there is no auto-repeat.
REQ-024 clr SHALL set entry_value=0 and digit_count=0 on the next edge. If clr coincides with acceptance, clr wins for entry_value and digit_count; key_valid and key_code still update. clr does not affect the FSM.
REQ-025 When more than one row is low, the lowest row index SHALL win. Other columns are not detected until release completes.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set: state=SCAN, c=0, col_out=4'b1110, scan_cnt=0, db_cnt=0, synchronizer flops=1, key_valid=0, key_code=0, entry_value=0, digit_count=0, key_held=0.
REQ-027 rst SHALL override clr and all state transitions. Reset mid-debounce or mid-hold discards the press with no key_valid.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8, WIDTH=32)
REQ-028 Release rst with row_in=4'hF, no press -> col_out cycles 1110,1101,1011,0111, each held 4 cycles; key_valid never asserts.
REQ-029 Hold row1 low while col_out=1101 until release, then release -> exactly one key_valid with key_code=5; entry_value=0x00000005; digit_count=1.
REQ-030 Enter keys 1,2,3,A,4,5,6,B,7 -> entry_value=0x23A456B7; digit_count=8 (saturated).
REQ-031 Glitch: row0 low for 3 cycles during DEBOUNCE -> return to SCAN, no key_valid. Release bounce: rows high 3 cycles then low again -> back to HOLD, no second key_valid.
REQ-032 clr asserted on the acceptance cycle of key 9 -> key_valid=1, key_code=9, entry_value=0, digit_count=0.
REQ-033 rst asserted during HOLD -> all outputs at reset values next cycle; a later release produces no key_valid.

Source files
------------

// File: rtl/keypad_hex_entry_if.sv
// keypad_hex_entry_if: keypad pins and hex entry results of keypad_hex_entry
interface keypad_hex_entry_if #(parameter int WIDTH = 32);
  localparam int DCW = $clog2(WIDTH / 4) + 1;
  logic [3:0] row_in;
  logic clr;
  logic [3:0] col_out;
  logic key_valid;
  logic [3:0] key_code;
  logic [WIDTH-1:0] entry_value;
  logic [DCW-1:0] digit_count;
  logic key_held;
  modport master (
    output row_in, clr,
    input col_out, key_valid, key_code, entry_value, digit_count, key_held
  );
  modport slave (
    input row_in, clr,
    output col_out, key_valid, key_code, entry_value, digit_count, key_held
  );
endinterface

// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: 4x4 keypad scanner with debounce, assembling a shift-in hex entry
module keypad_hex_entry #(
  parameter int WIDTH = 32,
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE_CNT = 1000000
) (
  input logic clk,
  input logic rst,
  keypad_hex_entry_if.slave bus
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam int DCW = $clog2(WIDTH / 4) + 1;
  localparam logic [DCW-1:0] MAX_DIGITS = DCW'(WIDTH / 4);
  // nibble {r,c} holds the hex legend of the key at row r, column c
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;
  state_t state, state_n;
  logic [3:0] rows_m, rows_s;
  logic [1:0] c, c_n, r, r_n, low_row;
  logic [SW-1:0] scan_cnt, scan_n;
  logic [DW-1:0] db_cnt, db_n;
  logic scan_last, db_last, any_low, accept;
  logic [3:0] code;
  assign scan_last = scan_cnt == SW'(SCAN_DIV - 1);
  assign db_last = db_cnt == DW'(DEBOUNCE_CNT - 1);
  assign any_low = rows_s != 4'hF;
  assign low_row = !rows_s[0] ? 2'd0 : !rows_s[1] ? 2'd1 : !rows_s[2] ? 2'd2 : 2'd3;
  assign code = KEY_MAP[{r, c, 2'b00} +: 4];
  assign bus.col_out = ~(4'b0001 << c);
  assign bus.key_held = state == HOLD || state == RELEASE;
  always_comb begin
    state_n = state;
    c_n = c;
    r_n = r;
    scan_n = scan_cnt;
    db_n = db_cnt;
    accept = 1'b0;
    unique case (state)
      SCAN: begin
        scan_n = scan_last ? '0 : scan_cnt + 1'b1;
        if (scan_last && any_low) begin
          state_n = DEBOUNCE;
          r_n = low_row;
          db_n = '0;
        end else if (scan_last) begin
          c_n = c + 2'd1;
        end
      end
      DEBOUNCE: begin
        if (rows_s[r]) begin
          state_n = SCAN;
          c_n = c + 2'd1;
          scan_n = '0;
        end else if (db_last) begin
          state_n = HOLD;
          accept = 1'b1;
        end else begin
          db_n = db_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!any_low) begin
          state_n = RELEASE;
          db_n = '0;
        end
      end
      RELEASE: begin
        if (any_low) begin
          state_n = HOLD;
        end else if (db_last) begin
          state_n = SCAN;
          c_n = c + 2'd1;
          scan_n = '0;
        end else begin
          db_n = db_cnt + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCAN;
      c <= '0;
      r <= '0;
      scan_cnt <= '0;
      db_cnt <= '0;
      rows_m <= 4'hF;
      rows_s <= 4'hF;
      bus.key_valid <= 1'b0;
      bus.key_code <= '0;
      bus.entry_value <= '0;
      bus.digit_count <= '0;
    end else begin
      rows_m <= bus.row_in;
      rows_s <= rows_m;
      state <= state_n;
      c <= c_n;
      r <= r_n;
      scan_cnt <= scan_n;
      db_cnt <= db_n;
      bus.key_valid <= accept;
      bus.key_code <= accept ? code : bus.key_code;
      bus.entry_value <= bus.clr ? '0 : accept ? {bus.entry_value[WIDTH-5:0], code} : bus.entry_value;
      bus.digit_count <= bus.clr ? '0 : (accept && bus.digit_count != MAX_DIGITS) ? bus.digit_count + 1'b1 : bus.digit_count;
    end
  end
endmodule
